// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST response analyzer.
//   mbist_state_e : analyzer FSM encoding
//   entry_w()     : width of one fail-log entry ({addr, expected bit})
//   sat_inc()     : saturating increment for counters up to 32 bits wide
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } mbist_state_e;

  function automatic int entry_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Increments val, holding at 2^width-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : (val + 32'd1);
  endfunction

endpackage

// File: rtl/mbist_fail_fifo.sv
// Fail-log FIFO for the MBIST response analyzer.
// Synchronous FIFO with a registered head entry that only changes on a pop
// or on a push into an empty FIFO, so it is stable while the consumer stalls.
// A push into a full FIFO is accepted when a pop happens in the same cycle;
// otherwise it is dropped and o_drop pulses.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : synchronous clear of all entries
//   i_push, i_data : write request and entry
//   i_pop          : read request (ignored when empty)
//   o_empty        : no entries stored
//   o_drop         : push rejected because the FIFO was full
//   o_head         : registered oldest entry
module mbist_fail_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_empty,
  output logic         o_drop,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_head;

  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic [AW:0]  w_rd_ptr_nxt;
  logic [W-1:0] w_head_nxt;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop        = i_pop & ~w_empty;
  assign w_push       = i_push & (~w_full | w_pop);
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // If the push lands in the slot that becomes the head, forward it directly.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0])) begin
      w_head_nxt = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_push};
      if (w_pop || (w_push && w_empty)) begin
        r_head <= w_head_nxt;
      end
    end
  end

  assign o_empty = w_empty;
  assign o_drop  = i_push & ~w_push & ~i_flush;
  assign o_head  = r_head;

endmodule

// File: rtl/mbist_resp_analyzer.sv
// MBIST response analyzer.
// Tracks BIST read requests through an RD_LAT-deep pipeline, compares the
// returned memory bit against the expected bit, and logs failures.
//   clk, rst_n            : clock, async active-low reset
//   mode                  : 1 = BIST owns the memory
//   cs/we/oe_bist         : controller memory strobes
//   mem_addr, mem_pattern : request address and expected read value
//   mem_d_out             : memory read data, valid RD_LAT cycles after request
//   bist_done             : controller finished the march
//   fault_flag, fail_cnt  : sticky fault, saturating miscompare count
//   log_overflow          : sticky, a failure was dropped from the log
//   log_valid/ready/addr/exp : fail-log readout handshake
//   analysis_done         : every issued read has been compared
//
// state  | meaning
// IDLE   | not analysing; results and log held
// ACTIVE | capturing read requests
// DRAIN  | no new requests; waiting for pipeline and fail register to empty
// DONE   | analysis complete, held until mode drops
module mbist_resp_analyzer
  import mbist_pkg::*;
#(
  parameter int ADDR   = 6,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             cs_bist,
  input  logic             we_bist,
  input  logic             oe_bist,
  input  logic [ADDR-1:0]  mem_addr,
  input  logic             mem_pattern,
  input  logic             mem_d_out,
  input  logic             bist_done,
  output logic             fault_flag,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             log_overflow,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [ADDR-1:0]  log_addr,
  output logic             log_exp,
  output logic             analysis_done
);

  localparam int EW  = entry_w(ADDR);
  localparam int DCW = $clog2(RD_LAT + 1);

  mbist_state_e     r_state;
  mbist_state_e     w_state_nxt;
  logic [DCW-1:0]   r_drain_cnt;
  logic             w_drain_load;

  logic             r_pipe_vld [RD_LAT];
  logic [EW-1:0]    r_pipe_ent [RD_LAT];
  logic             r_fail;
  logic [EW-1:0]    r_fail_ent;

  logic             r_fault;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_log_ovf;

  logic             w_rd_req;
  logic             w_abort;
  logic             w_clear;
  logic             w_miscmp;
  logic             w_pop;
  logic             w_fifo_empty;
  logic             w_fifo_drop;
  logic [EW-1:0]    w_fifo_head;

  assign w_rd_req = mode & cs_bist & oe_bist & ~we_bist & (r_state == ST_ACTIVE);
  // mode falling mid-analysis: abandon in-flight reads.
  assign w_abort  = ~mode & ((r_state == ST_ACTIVE) | (r_state == ST_DRAIN));
  assign w_clear  = mode & (r_state == ST_IDLE);
  assign w_miscmp = r_pipe_vld[RD_LAT-1] & (mem_d_out != r_pipe_ent[RD_LAT-1][0]);
  assign w_pop    = ~w_fifo_empty & log_ready;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mode) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!mode) begin
          w_state_nxt = ST_IDLE;
        end else if (bist_done) begin
          w_state_nxt  = ST_DRAIN;
          w_drain_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!mode) begin
          w_state_nxt = ST_IDLE;
        end else if (r_drain_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!mode) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Loaded with RD_LAT, so DRAIN lasts RD_LAT+1 cycles: the last request
  // reaches the compare and its fail pulse is consumed on the DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (w_drain_load) begin
      r_drain_cnt <= DCW'(RD_LAT);
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - DCW'(1);
    end
  end

  // Read pipeline and compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_ent[i] <= '0;
      end
      r_fail     <= 1'b0;
      r_fail_ent <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_req;
      r_pipe_ent[0] <= {mem_addr, mem_pattern};
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1] & ~w_abort;
        r_pipe_ent[i] <= r_pipe_ent[i-1];
      end
      r_fail     <= w_miscmp & ~w_abort;
      r_fail_ent <= r_pipe_ent[RD_LAT-1];
    end
  end

  // Results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault    <= 1'b0;
      r_fail_cnt <= '0;
      r_log_ovf  <= 1'b0;
    end else if (w_clear) begin
      r_fault    <= 1'b0;
      r_fail_cnt <= '0;
      r_log_ovf  <= 1'b0;
    end else if (r_fail) begin
      r_fault    <= 1'b1;
      r_fail_cnt <= CNT_W'(sat_inc(32'(r_fail_cnt), CNT_W));
      if (w_fifo_drop) r_log_ovf <= 1'b1;
    end
  end

  mbist_fail_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fail_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (w_clear),
    .i_push  (r_fail),
    .i_data  (r_fail_ent),
    .i_pop   (w_pop),
    .o_empty (w_fifo_empty),
    .o_drop  (w_fifo_drop),
    .o_head  (w_fifo_head)
  );

  assign fault_flag    = r_fault;
  assign fail_cnt      = r_fail_cnt;
  assign log_overflow  = r_log_ovf;
  assign log_valid     = ~w_fifo_empty;
  assign log_addr      = w_fifo_head[EW-1:1];
  assign log_exp       = w_fifo_head[0];
  assign analysis_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_mbist_resp_analyzer.sv
// Bench for mbist_resp_analyzer: acts as the MBIST controller and memory,
// queues each expected log entry when a faulty read is issued and compares
// entries as they are drained from the log port.
module tb_mbist_resp_analyzer;

  localparam int ADDR   = 6;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             cs_bist = 1'b0;
  logic             we_bist = 1'b0;
  logic             oe_bist = 1'b0;
  logic [ADDR-1:0]  mem_addr = '0;
  logic             mem_pattern = 1'b0;
  logic             mem_d_out = 1'b0;
  logic             bist_done = 1'b0;
  logic             fault_flag;
  logic [CNT_W-1:0] fail_cnt;
  logic             log_overflow;
  logic             log_valid;
  logic             log_ready = 1'b0;
  logic [ADDR-1:0]  log_addr;
  logic             log_exp;
  logic             analysis_done;

  int total = 0;
  int bad   = 0;

  logic          stuck_en  [64];
  logic          stuck_val [64];
  logic          next_dout = 1'b0;
  logic [ADDR:0] exp_q [$];
  int            exp_fails = 0;

  always #5 clk = ~clk;

  mbist_resp_analyzer #(
    .ADDR(ADDR), .RD_LAT(RD_LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .cs_bist(cs_bist), .we_bist(we_bist),
    .oe_bist(oe_bist), .mem_addr(mem_addr), .mem_pattern(mem_pattern),
    .mem_d_out(mem_d_out), .bist_done(bist_done), .fault_flag(fault_flag),
    .fail_cnt(fail_cnt), .log_overflow(log_overflow), .log_valid(log_valid),
    .log_ready(log_ready), .log_addr(log_addr), .log_exp(log_exp),
    .analysis_done(analysis_done)
  );

  // Memory holds the value the march wrote, which equals the expected bit,
  // unless a stuck-at fault is planted at that address.
  task automatic do_read(input logic [ADDR-1:0] a, input logic p, input logic done,
                         input bit scored);
    @(negedge clk);
    mem_d_out   = next_dout;
    cs_bist     = 1'b1;
    oe_bist     = 1'b1;
    we_bist     = 1'b0;
    mem_addr    = a;
    mem_pattern = p;
    bist_done   = done;
    next_dout   = stuck_en[a] ? stuck_val[a] : p;
    if (scored && (next_dout != p)) begin
      exp_q.push_back({a, p});
      exp_fails++;
    end
  endtask

  task automatic idle_cycle(input logic done);
    @(negedge clk);
    mem_d_out = next_dout;
    next_dout = 1'b0;
    cs_bist   = 1'b0;
    oe_bist   = 1'b0;
    bist_done = done;
  endtask

  task automatic start_run();
    @(negedge clk);
    mode = 1'b0;
    cs_bist = 1'b0;
    oe_bist = 1'b0;
    bist_done = 1'b0;
    log_ready = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    exp_q.delete();
    exp_fails = 0;
    for (int i = 0; i < 64; i++) begin
      stuck_en[i]  = 1'b0;
      stuck_val[i] = 1'b0;
    end
  endtask

  task automatic run_to_done(input string tag, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      idle_cycle(1'b0);
      if (analysis_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL %s done_timeout: analysis_done never rose", tag);
    end
  endtask

  task automatic drain_log(input string tag);
    logic [ADDR:0] e;
    for (int k = 0; k < DEPTH + 4; k++) begin
      @(negedge clk);
      if (log_valid !== 1'b1) break;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s extra_entry: got %h expected none", tag, {log_addr, log_exp});
      end else begin
        e = exp_q.pop_front();
        if ({log_addr, log_exp} !== e) begin
          bad++;
          $display("FAIL %s entry: got addr=%h exp=%b expected addr=%h exp=%b",
                   tag, log_addr, log_exp, e[ADDR:1], e[0]);
        end
      end
      log_ready = 1'b1;
    end
    log_ready = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_entries: got none expected %0d more", tag, exp_q.size());
    end
    total++;
    if (log_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s valid_after_drain: got %b expected 0", tag, log_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({fault_flag, fail_cnt, log_overflow, log_valid, log_addr, log_exp, analysis_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ff=%b cnt=%0d ovf=%b vld=%b addr=%h exp=%b done=%b expected all 0",
               fault_flag, fail_cnt, log_overflow, log_valid, log_addr, log_exp, analysis_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fault_free();
    int lat;
    start_run();
    for (int a = 0; a < 64; a++) do_read(6'(a), 1'b0, (a == 63), 1'b1);
    run_to_done("fault_free", lat);
    total++;
    if (lat != RD_LAT + 2) begin
      bad++;
      $display("FAIL fault_free done_latency: got %0d expected %0d", lat, RD_LAT + 2);
    end
    total++;
    if ({fault_flag, fail_cnt, log_valid, log_overflow} !== '0) begin
      bad++;
      $display("FAIL fault_free results: got ff=%b cnt=%0d vld=%b ovf=%b expected all 0",
               fault_flag, fail_cnt, log_valid, log_overflow);
    end
  endtask

  task automatic test_stuck_single();
    int lat;
    start_run();
    stuck_en[21] = 1'b1;
    stuck_val[21] = 1'b1;
    for (int a = 16; a < 32; a++) do_read(6'(a), 1'b0, (a == 31), 1'b1);
    run_to_done("stuck_single", lat);
    total++;
    if (fault_flag !== 1'b1) begin
      bad++;
      $display("FAIL stuck_single fault_flag: got %b expected 1", fault_flag);
    end
    total++;
    if (fail_cnt !== CNT_W'(exp_fails)) begin
      bad++;
      $display("FAIL stuck_single fail_cnt: got %0d expected %0d", fail_cnt, exp_fails);
    end
    drain_log("stuck_single");
    // In DONE, further read requests must be ignored.
    do_read(6'h15, 1'b0, 1'b0, 1'b0);
    repeat (3) idle_cycle(1'b0);
    total++;
    if (fail_cnt !== CNT_W'(exp_fails) || log_valid !== 1'b0) begin
      bad++;
      $display("FAIL ignore_outside_active: got cnt=%0d vld=%b expected cnt=%0d vld=0",
               fail_cnt, log_valid, exp_fails);
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_run();
    for (int a = 1; a <= 6; a++) begin
      stuck_en[a]  = 1'b1;
      stuck_val[a] = ~a[0];
    end
    for (int a = 1; a <= 6; a++) do_read(6'(a), a[0], (a == 6), 1'b1);
    run_to_done("overflow", lat);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    total++;
    if (fail_cnt !== CNT_W'(exp_fails)) begin
      bad++;
      $display("FAIL overflow fail_cnt: got %0d expected %0d", fail_cnt, exp_fails);
    end
    total++;
    if (log_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow flag: got %b expected 1", log_overflow);
    end
    // Head must stay put while the consumer stalls.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({log_addr, log_exp} !== exp_q[0]) begin
        bad++;
        $display("FAIL overflow head_stable: got %h expected %h", {log_addr, log_exp}, exp_q[0]);
      end
    end
    drain_log("overflow");
  endtask

  task automatic test_full_push_pop();
    logic [ADDR:0] e;
    start_run();
    for (int a = 1; a <= 5; a++) begin
      stuck_en[a]  = 1'b1;
      stuck_val[a] = 1'b1;
    end
    for (int a = 1; a <= 5; a++) do_read(6'(a), 1'b0, 1'b0, 1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    // FIFO now holds four entries and the fifth fail pushes at the next edge.
    e = exp_q.pop_front();
    total++;
    if (log_valid !== 1'b1 || {log_addr, log_exp} !== e) begin
      bad++;
      $display("FAIL pushpop head: got vld=%b %h expected vld=1 %h", log_valid, {log_addr, log_exp}, e);
    end
    log_ready = 1'b1;
    idle_cycle(1'b0);
    log_ready = 1'b0;
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    total++;
    if (log_overflow !== 1'b0) begin
      bad++;
      $display("FAIL pushpop overflow: got %b expected 0", log_overflow);
    end
    total++;
    if (fail_cnt !== CNT_W'(exp_fails)) begin
      bad++;
      $display("FAIL pushpop fail_cnt: got %0d expected %0d", fail_cnt, exp_fails);
    end
    drain_log("pushpop");
  endtask

  task automatic test_reset_mid_active();
    int lat;
    start_run();
    for (int a = 1; a <= 3; a++) begin
      stuck_en[a]  = 1'b1;
      stuck_val[a] = 1'b1;
    end
    for (int a = 1; a <= 3; a++) do_read(6'(a), 1'b0, 1'b0, 1'b1);
    repeat (3) idle_cycle(1'b0);
    total++;
    if (fail_cnt !== CNT_W'(exp_fails)) begin
      bad++;
      $display("FAIL midreset pre_cnt: got %0d expected %0d", fail_cnt, exp_fails);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({fault_flag, fail_cnt, log_overflow, log_valid, log_addr, log_exp, analysis_done} !== '0) begin
      bad++;
      $display("FAIL midreset outputs: got ff=%b cnt=%0d ovf=%b vld=%b addr=%h exp=%b done=%b expected all 0",
               fault_flag, fail_cnt, log_overflow, log_valid, log_addr, log_exp, analysis_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_fails = 0;
    for (int i = 0; i < 64; i++) stuck_en[i] = 1'b0;
    for (int a = 0; a < 8; a++) do_read(6'(a), a[1], (a == 7), 1'b1);
    run_to_done("midreset_rerun", lat);
    total++;
    if (fail_cnt !== '0 || fault_flag !== 1'b0) begin
      bad++;
      $display("FAIL midreset rerun: got cnt=%0d ff=%b expected cnt=0 ff=0", fail_cnt, fault_flag);
    end
  endtask

  task automatic test_mode_drop();
    start_run();
    stuck_en[7]  = 1'b1;
    stuck_val[7] = 1'b1;
    do_read(6'h07, 1'b0, 1'b0, 1'b1);
    repeat (3) idle_cycle(1'b0);
    do_read(6'h08, 1'b0, 1'b1, 1'b1);
    idle_cycle(1'b0);
    mode = 1'b0;
    repeat (4) idle_cycle(1'b0);
    total++;
    if (analysis_done !== 1'b0) begin
      bad++;
      $display("FAIL modedrop done: got %b expected 0", analysis_done);
    end
    total++;
    if (fail_cnt !== CNT_W'(exp_fails) || fault_flag !== 1'b1 || log_valid !== 1'b1) begin
      bad++;
      $display("FAIL modedrop held: got cnt=%0d ff=%b vld=%b expected cnt=%0d ff=1 vld=1",
               fail_cnt, fault_flag, log_valid, exp_fails);
    end
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    total++;
    if ({fault_flag, fail_cnt, log_overflow, log_valid} !== '0) begin
      bad++;
      $display("FAIL modedrop restart_clear: got ff=%b cnt=%0d ovf=%b vld=%b expected all 0",
               fault_flag, fail_cnt, log_overflow, log_valid);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      stuck_en[i]  = 1'b0;
      stuck_val[i] = 1'b0;
    end
    test_reset();
    test_fault_free();
    test_stuck_single();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_active();
    test_mode_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
